next_pc_unit: RTL and testbench
===============================

// Module: next_pc_unit
// PURPOSE
//  Fetch-PC generator and branch-outcome checker sitting directly downstream of the branch predictor.
//  Consumes the ID-stage taken/not-taken prediction and the RAS jalr target, and redirects fetch in ID.
//  Carries each prediction to EX, compares it with the resolved outcome and raises PL_flush on a mispredict.
//  Produces the redirect target and saturating branch/mispredict statistics.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address loaded on reset
//  CNT_WIDTH   16             width of the saturating branch and mispredict counters
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   synchronous reset, active-high
//  PL_stall         in   1   pipeline stall: hold PC and the ID->EX tracking register
//  pc_if            out  32  current fetch address
//  valid_id         in   1   ID-stage instruction is valid (not a bubble)
//  B_type_id        in   1   ID instruction is a conditional branch
//  jal_id           in   1   ID instruction is jal
//  jalr_id          in   1   ID instruction is jalr
//  pc_id            in   32  PC of the ID instruction
//  imme_id          in   32  sign-extended immediate of the ID instruction
//  prediction_id    in   1   predictor's taken result for the ID branch
//  jalr_pc_pred     in   32  RAS target prediction for the ID jalr
//  redirect_id      out  1   ID redirect taken this cycle; squash the IF instruction
//  taken_ex         in   1   resolved branch condition in EX
//  jalr_target_ex   in   32  resolved jalr target in EX (LSB already cleared)
//  PL_flush         out  1   EX mispredict: flush IF/ID and ID/EX
//  B_type_failed    out  1   mispredicted instruction was a conditional branch
//  jalr_failed      out  1   mispredicted instruction was a jalr
//  pc_failed        out  32  PC of the mispredicted instruction (drives predictor rollback)
//  corrected_result out  1   actual taken value of the failed branch
//  branch_cnt       out  CNT_WIDTH  resolved B_type+jalr count, saturating
//  mispred_cnt      out  CNT_WIDTH  mispredict count, saturating
// BEHAVIOUR
//  - Reset: pc_if=RESET_PC; tracker valid=0; state=RUN; counters=0; all 1-bit outputs 0; pc_failed=0.
//  - Next-PC priority, registered into pc_if on the edge:
//    (1) rst; (2) PL_flush -> correct_target; (3) PL_stall -> hold;
//    (4) redirect_id -> id_target; (5) pc_if+4.
//  - redirect_id = valid_id & !PL_flush & state==RUN & (jal_id | jalr_id | (B_type_id & prediction_id)).
//  - id_target = jalr_id ? jalr_pc_pred : pc_id+imme_id. Adds are 32-bit modulo; wrap at 2^32 is silent.
//  - Tracker register: loads when !PL_stall & !PL_flush, capturing {valid_id & (B_type_id|jalr_id), B_type_id,
//    jalr_id, pred_taken=prediction_id, pred_tgt=id_target, br_tgt=pc_id+imme_id, pc_p4=pc_id+4, pc_id}.
//  - Tracker: valid cleared on PL_flush, which overrides PL_stall; under PL_stall alone all fields hold.
//  - EX check, combinational, same cycle; all terms are qualified by tracker valid and state==RUN:
//    b_fail = B_type & (taken_ex != pred_taken); j_fail = jalr & (jalr_target_ex != pred_tgt).
//  - PL_flush = b_fail|j_fail. The flush asserts even while PL_stall is high.
//  - correct_target = j_fail ? jalr_target_ex : (taken_ex ? br_tgt : pc_p4).
//  - B_type_failed/jalr_failed/pc_failed/corrected_result are valid only while PL_flush=1; otherwise 0.
//  - FSM RUN -> RECOVER on PL_flush.
//    RECOVER lasts exactly 1 cycle, then returns to RUN; it ignores PL_stall.
//    In RECOVER, redirect_id and the EX check are masked: those stages hold wrong-path bubbles.
//  - Counters update only when !PL_stall, in RUN, with tracker valid.
//    branch_cnt +1 per resolved B_type/jalr; mispred_cnt +1 on PL_flush.
//    Both saturate at all-ones; no wrap.
//  - Reset mid-flush: rst wins, and the FSM returns to RUN with pc_if=RESET_PC.
// STRUCTURE
//  - Shared package bp_pkg: RESET_PC default, FSM state encoding {RUN,RECOVER}, next-PC select encoding.
//  - One sub-module: pred_track_reg holds the ID->EX tracking register plus its valid/flush/stall logic.
//  - The PC mux, the EX comparator, the FSM and the counters live in the top module.
// TESTING
//  1. Reset, then 3 cycles, no stall -> pc_if 0x0, 0x4, 0x8, 0xC; all flags 0.
//  2. ID bne pc_id=0x100, imme=-16, prediction_id=1 -> redirect_id=1.
//     Next pc_if=0xF0. In EX, taken_ex=0 -> PL_flush=1, B_type_failed=1, pc_failed=0x100, corrected_result=0.
//     Next pc_if=0x104; mispred_cnt=1.
//  3. ID jalr, jalr_pc_pred=0x200 -> pc_if=0x200.
//     EX jalr_target_ex=0x208 -> jalr_failed=1, next pc_if=0x208.
//     Repeat with 0x200 -> no flush, branch_cnt+1.
//  4. PL_flush and PL_stall together -> pc_if takes correct_target; tracker valid=0.
//     The next cycle is RECOVER with redirect_id=0, even with jal_id=1.
//  5. Drive 2^CNT_WIDTH+3 mispredicts (CNT_WIDTH=4 build) -> mispred_cnt stays 4'hF.
//  6. rst asserted during the PL_flush cycle -> pc_if=RESET_PC, state RUN, counters 0 next cycle.

Source files
------------

// File: rtl/next_pc_unit_pkg.sv
// Shared types for the next-PC unit: reset PC default, FSM states, PC-select codes, tracker record.
// Pure declarations; no logic, no latency, no backpressure.
package bp_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ      = 2'd0,
    SEL_REDIRECT = 2'd1,
    SEL_HOLD     = 2'd2,
    SEL_CORRECT  = 2'd3
  } pc_sel_t;

  // One in-flight prediction carried from ID to EX.
  typedef struct packed {
    logic        vld;
    logic        b_type;
    logic        jalr;
    logic        pred_taken;
    logic [31:0] pred_tgt;
    logic [31:0] br_tgt;
    logic [31:0] pc_p4;
    logic [31:0] pc;
  } track_t;

endpackage

// File: rtl/next_pc_unit_if.sv
// ID/EX-side bundle of the next-PC unit; master is the pipeline, slave is next_pc_unit.
// Wires only; no latency, no backpressure beyond PL_stall.
interface next_pc_unit_if;
  logic        PL_stall;
  logic [31:0] pc_if;
  logic        valid_id;
  logic        B_type_id;
  logic        jal_id;
  logic        jalr_id;
  logic [31:0] pc_id;
  logic [31:0] imme_id;
  logic        prediction_id;
  logic [31:0] jalr_pc_pred;
  logic        redirect_id;
  logic        taken_ex;
  logic [31:0] jalr_target_ex;
  logic        PL_flush;
  logic        B_type_failed;
  logic        jalr_failed;
  logic [31:0] pc_failed;
  logic        corrected_result;

  modport master (
    output PL_stall, valid_id, B_type_id, jal_id, jalr_id, pc_id, imme_id,
           prediction_id, jalr_pc_pred, taken_ex, jalr_target_ex,
    input  pc_if, redirect_id, PL_flush, B_type_failed, jalr_failed,
           pc_failed, corrected_result
  );

  modport slave (
    input  PL_stall, valid_id, B_type_id, jal_id, jalr_id, pc_id, imme_id,
           prediction_id, jalr_pc_pred, taken_ex, jalr_target_ex,
    output pc_if, redirect_id, PL_flush, B_type_failed, jalr_failed,
           pc_failed, corrected_result
  );
endinterface

// File: rtl/next_pc_unit_pred_track_reg.sv
// ID->EX prediction tracker: one-cycle register, loads when neither stalled nor flushed.
// Stall holds every field; flush drops valid and wins over stall.
module pred_track_reg
  import bp_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  track_t load_dat,
  output track_t trk_q
);

  track_t trk_d;

  always_comb begin
    trk_d = trk_q;
    if (flush) begin
      trk_d.vld = 1'b0;
    end else if (!stall) begin
      trk_d = load_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_q <= '0;
    end else begin
      trk_q <= trk_d;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch-PC mux, ID redirect, EX mispredict check, recover FSM and saturating stats.
// Redirect/flush are combinational in the same cycle; pc_if updates next edge; PL_stall holds PC unless flushing.
module next_pc_unit
  import bp_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  next_pc_unit_if.slave        bus,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  pc_sel_t               pc_sel;
  logic [31:0]           pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;
  track_t                trk_q, trk_load;
  logic                  run, chk, b_fail, j_fail, flush, redirect, cnt_en;
  logic [31:0]           br_tgt_id, id_target, correct_target;

  assign run = (state_q == ST_RUN);
  assign chk = trk_q.vld & run;

  assign b_fail = chk & trk_q.b_type & (bus.taken_ex != trk_q.pred_taken);
  assign j_fail = chk & trk_q.jalr & (bus.jalr_target_ex != trk_q.pred_tgt);
  assign flush  = b_fail | j_fail;

  assign redirect = bus.valid_id & ~flush & run &
                    (bus.jal_id | bus.jalr_id | (bus.B_type_id & bus.prediction_id));

  assign br_tgt_id      = bus.pc_id + bus.imme_id;
  assign id_target      = bus.jalr_id ? bus.jalr_pc_pred : br_tgt_id;
  assign correct_target = j_fail ? bus.jalr_target_ex
                                 : (bus.taken_ex ? trk_q.br_tgt : trk_q.pc_p4);

  always_comb begin
    if (flush) begin
      pc_sel = SEL_CORRECT;
    end else if (bus.PL_stall) begin
      pc_sel = SEL_HOLD;
    end else if (redirect) begin
      pc_sel = SEL_REDIRECT;
    end else begin
      pc_sel = SEL_SEQ;
    end
  end

  always_comb begin
    pc_d = pc_q + 32'd4;
    case (pc_sel)
      SEL_CORRECT:  pc_d = correct_target;
      SEL_HOLD:     pc_d = pc_q;
      SEL_REDIRECT: pc_d = id_target;
      default:      pc_d = pc_q + 32'd4;
    endcase
  end

  always_comb begin
    trk_load            = '0;
    trk_load.vld        = bus.valid_id & (bus.B_type_id | bus.jalr_id);
    trk_load.b_type     = bus.B_type_id;
    trk_load.jalr       = bus.jalr_id;
    trk_load.pred_taken = bus.prediction_id;
    trk_load.pred_tgt   = id_target;
    trk_load.br_tgt     = br_tgt_id;
    trk_load.pc_p4      = bus.pc_id + 32'd4;
    trk_load.pc         = bus.pc_id;
  end

  pred_track_reg u_track (
    .clk      (clk),
    .rst      (rst),
    .stall    (bus.PL_stall),
    .flush    (flush),
    .load_dat (trk_load),
    .trk_q    (trk_q)
  );

  // RECOVER is a single bubble cycle and ignores stall.
  always_comb begin
    state_d = ST_RUN;
    if (run && flush) begin
      state_d = ST_RECOVER;
    end
  end

  assign cnt_en = ~bus.PL_stall & run & trk_q.vld;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (cnt_en) begin
      if (branch_cnt_q != CNT_MAX) begin
        branch_cnt_d = branch_cnt_q + CNT_ONE;
      end
      if (flush && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_d = mispred_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.pc_if            = pc_q;
  assign bus.redirect_id      = redirect;
  assign bus.PL_flush         = flush;
  assign bus.B_type_failed    = b_fail;
  assign bus.jalr_failed      = j_fail;
  assign bus.pc_failed        = flush ? trk_q.pc : 32'h0;
  assign bus.corrected_result = b_fail ? bus.taken_ex : j_fail;
  assign branch_cnt           = branch_cnt_q;
  assign mispred_cnt          = mispred_cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: directed scenarios plus random traffic, checked by a scoreboard against a
// cycle-level reference model of the fetch/predict/resolve rules.
module tb_next_pc_unit;

  localparam int          CW  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  next_pc_unit_if bus ();

  next_pc_unit #(.RESET_PC(RPC), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        redirect, flush, bf, jf;
    logic [31:0] pcf;
    logic        corr;
    int          bcnt, mcnt;
  } exp_t;

  typedef struct {
    bit          vld, b, j, pt;
    logic [31:0] ptgt, brt, pcp4, pc;
  } slot_t;

  exp_t        sb[$];
  logic [31:0] m_pc;
  bit          m_recover;
  bit          m_known = 1'b0;
  int          m_bcnt, m_mcnt;
  slot_t       m_slot;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic int sat_inc(input int c);
    return (c >= (1 << CW) - 1) ? c : c + 1;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc      = RPC;
    m_recover = 1'b0;
    m_bcnt    = 0;
    m_mcnt    = 0;
    m_slot    = '{default: '0};
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, then advance the model past the edge.
  task automatic cyc(input bit r, input bit st, input bit v, input bit b, input bit jl, input bit jr,
                     input logic [31:0] pcid, input logic [31:0] imm, input bit pred,
                     input logic [31:0] jpred, input bit tk, input logic [31:0] jt);
    exp_t        e;
    bit          run, chk, bfail, jfail, fl, rd;
    logic [31:0] brt, idt;
    @(posedge clk);
    #1;
    rst = r;
    bus.PL_stall = st;       bus.valid_id = v;       bus.B_type_id = b;
    bus.jal_id = jl;         bus.jalr_id = jr;       bus.pc_id = pcid;
    bus.imme_id = imm;       bus.prediction_id = pred;
    bus.jalr_pc_pred = jpred; bus.taken_ex = tk;     bus.jalr_target_ex = jt;

    run   = !m_recover;
    chk   = m_slot.vld && run;
    bfail = chk && m_slot.b && (tk != m_slot.pt);
    jfail = chk && m_slot.j && (jt != m_slot.ptgt);
    fl    = bfail || jfail;
    rd    = v && !fl && run && (jl || jr || (b && pred));
    brt   = pcid + imm;
    idt   = jr ? jpred : brt;

    e.pc = m_pc; e.redirect = rd; e.flush = fl; e.bf = bfail; e.jf = jfail;
    e.pcf = fl ? m_slot.pc : 32'h0;
    e.corr = bfail ? tk : jfail;
    e.bcnt = m_bcnt; e.mcnt = m_mcnt;
    if (m_known) sb.push_back(e);

    if (r) begin
      m_reset();
      m_known = 1'b1;
    end else begin
      if (!st && run && m_slot.vld) begin
        m_bcnt = sat_inc(m_bcnt);
        if (fl) m_mcnt = sat_inc(m_mcnt);
      end
      if (fl)       m_pc = jfail ? jt : (tk ? m_slot.brt : m_slot.pcp4);
      else if (!st) m_pc = rd ? idt : m_pc + 32'd4;
      if (fl) begin
        m_slot.vld = 1'b0;
      end else if (!st) begin
        m_slot.vld = v && (b || jr); m_slot.b = b; m_slot.j = jr; m_slot.pt = pred;
        m_slot.ptgt = idt; m_slot.brt = brt; m_slot.pcp4 = pcid + 32'd4; m_slot.pc = pcid;
      end
      m_recover = fl;
    end
  endtask

  task automatic idle(input bit tk, input logic [31:0] jt);
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, tk, jt);
  endtask

  // Monitor: every sampled cycle has a pending expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("pc_if",            bus.pc_if,                e.pc);
        cmp("redirect_id",      32'(bus.redirect_id),     32'(e.redirect));
        cmp("PL_flush",         32'(bus.PL_flush),        32'(e.flush));
        cmp("B_type_failed",    32'(bus.B_type_failed),   32'(e.bf));
        cmp("jalr_failed",      32'(bus.jalr_failed),     32'(e.jf));
        cmp("pc_failed",        bus.pc_failed,            e.pcf);
        cmp("corrected_result", 32'(bus.corrected_result), 32'(e.corr));
        cmp("branch_cnt",       32'(branch_cnt),          32'(e.bcnt));
        cmp("mispred_cnt",      32'(mispred_cnt),         32'(e.mcnt));
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.PL_stall = 0; bus.valid_id = 0; bus.B_type_id = 0; bus.jal_id = 0; bus.jalr_id = 0;
    bus.pc_id = 0; bus.imme_id = 0; bus.prediction_id = 0; bus.jalr_pc_pred = 0;
    bus.taken_ex = 0; bus.jalr_target_ex = 0;
    m_reset();

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Sequential fetch out of reset.
    repeat (4) idle(0, 0);
    @(negedge clk);
    cmp("d1_pc_c", bus.pc_if, 32'hC);
    cmp("d1_mcnt", 32'(mispred_cnt), 32'h0);

    // bne predicted taken, resolves not-taken.
    cyc(0, 0, 1, 1, 0, 0, 32'h100, 32'hFFFF_FFF0, 1, 32'h0, 0, 32'h0);
    @(negedge clk); cmp("d2_redirect", 32'(bus.redirect_id), 32'h1);
    idle(0, 0);
    @(negedge clk);
    cmp("d2_pc_f0", bus.pc_if, 32'hF0);
    cmp("d2_flush", 32'(bus.PL_flush), 32'h1);
    cmp("d2_bfail", 32'(bus.B_type_failed), 32'h1);
    cmp("d2_pcfail", bus.pc_failed, 32'h100);
    cmp("d2_corr", 32'(bus.corrected_result), 32'h0);
    idle(0, 0);
    @(negedge clk);
    cmp("d2_pc_104", bus.pc_if, 32'h104);
    cmp("d2_mcnt", 32'(mispred_cnt), 32'h1);

    // jalr RAS miss, then RAS hit.
    cyc(0, 0, 1, 0, 0, 1, 32'h108, 32'h0, 0, 32'h200, 0, 32'h0);
    idle(0, 32'h208);
    @(negedge clk);
    cmp("d3_pc_200", bus.pc_if, 32'h200);
    cmp("d3_jfail", 32'(bus.jalr_failed), 32'h1);
    idle(0, 0);
    @(negedge clk); cmp("d3_pc_208", bus.pc_if, 32'h208);
    cyc(0, 0, 1, 0, 0, 1, 32'h20C, 32'h0, 0, 32'h200, 0, 32'h0);
    idle(0, 32'h200);
    @(negedge clk); cmp("d3_noflush", 32'(bus.PL_flush), 32'h0);
    idle(0, 0);
    @(negedge clk); cmp("d3_bcnt", 32'(branch_cnt), 32'h3);

    // Flush while stalled, then RECOVER masks a jal.
    cyc(0, 0, 1, 1, 0, 0, 32'h300, 32'h40, 0, 32'h0, 0, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h0);
    @(negedge clk); cmp("d4_flush", 32'(bus.PL_flush), 32'h1);
    cyc(0, 0, 1, 0, 1, 0, 32'h340, 32'h80, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    cmp("d4_pc_340", bus.pc_if, 32'h340);
    cmp("d4_redirect", 32'(bus.redirect_id), 32'h0);

    // Saturate the mispredict counter.
    repeat ((1 << CW) + 3) begin
      cyc(0, 0, 1, 1, 0, 0, 32'h400, 32'h8, 1, 32'h0, 0, 32'h0);
      idle(0, 0);
      idle(0, 0);
    end
    @(negedge clk);
    cmp("d5_mcnt_sat", 32'(mispred_cnt), 32'hF);
    cmp("d5_bcnt_sat", 32'(branch_cnt), 32'hF);

    // Reset during the flush cycle.
    cyc(0, 0, 1, 1, 0, 0, 32'h500, 32'h10, 1, 32'h0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk); cmp("d6_flush", 32'(bus.PL_flush), 32'h1);
    cyc(0, 0, 1, 0, 1, 0, 32'h0, 32'h20, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    cmp("d6_pc_rst", bus.pc_if, RPC);
    cmp("d6_bcnt", 32'(branch_cnt), 32'h0);
    cmp("d6_run_redirect", 32'(bus.redirect_id), 32'h1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit          v, b, jl, jr, pred, st, r, tk;
      int          kind;
      logic [31:0] pcid, imm, jpred, jt;
      kind  = $urandom_range(0, 3);
      v     = ($urandom_range(0, 3) != 0);
      b     = (kind == 1);
      jl    = (kind == 2);
      jr    = (kind == 3);
      pred  = $urandom_range(0, 1);
      st    = ($urandom_range(0, 4) == 0);
      r     = ($urandom_range(0, 63) == 0);
      tk    = $urandom_range(0, 1);
      pcid  = $urandom & 32'hFFFF_FFFC;
      imm   = 32'($urandom_range(0, 255)) * 32'd4 - 32'd512;
      jpred = $urandom & 32'hFFFF_FFFC;
      jt    = (m_slot.j && $urandom_range(0, 1) == 1) ? m_slot.ptgt : ($urandom & 32'hFFFF_FFFE);
      cyc(r, st, v, b, jl, jr, pcid, imm, pred, jpred, tk, jt);
    end
    idle(0, 0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
